// File: rtl/mux_2to1_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// mux_2to1_rr_arbiter_if
//   Bundles the two valid/ready producer channels, the output register channel
//   and the mux select of the 2:1 round-robin arbiter stage.
//
//   Signals
//     in0_valid / in0_data / in0_ready : producer 0 handshake
//     in1_valid / in1_data / in1_ready : producer 1 handshake
//     out_valid / out_data / out_ready : output register handshake
//     select                           : source of the held word (0 = in0, 1 = in1)
//
//   Modports
//     master : the surroundings (producers and downstream consumer)
//     slave  : the arbiter itself
// ----------------------------------------------------------------------------
interface mux_2to1_rr_arbiter_if #(
    parameter int WIDTH = 1
);
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             select;

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, select
    );

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, select
    );
endinterface

// File: rtl/mux_2to1_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux_2to1_rr_arbiter
//   Select generator for the 2:1 multiplexer stage. Two valid/ready producers
//   compete for one output; a round-robin arbiter picks the winner, the winning
//   word is captured into a one-entry output register and 'select' records
//   which input it came from. Back-pressure on out_ready stalls the register
//   without losing or duplicating words; a drain and a load may happen in the
//   same cycle for full throughput.
//
//   Parameters
//     WIDTH : data width of each input word and of out_data
//     CNT_W : width of the per-input grant counters
//
//   Ports
//     clk        : clock, all state updates on posedge
//     reset      : synchronous, active-high
//     bus        : mux_2to1_rr_arbiter_if.slave (producer, output and select signals)
//     grant_cnt0 : accepted in0 words, saturating (GRANT_CNT_EN only)
//     grant_cnt1 : accepted in1 words, saturating (GRANT_CNT_EN only)
//
//   Configuration macro
//     GRANT_CNT_EN : when defined, adds the saturating grant counters and
//                    their output ports; when undefined they are absent.
// ----------------------------------------------------------------------------
module mux_2to1_rr_arbiter #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    mux_2to1_rr_arbiter_if.slave       bus
`ifdef GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0]           grant_cnt0,
    output logic [CNT_W-1:0]           grant_cnt1
`endif
);

    // The only state is whether the output register holds a word.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_outData;
    logic             r_select;
    logic             r_lastGrant;

    logic             w_load;
    logic             w_grant;
    logic             w_xfer0;
    logic             w_xfer1;

    // Parameter sanity checks at elaboration time.
    if (WIDTH < 1) begin : g_widthCheck
        $error("WIDTH must be at least 1");
    end
    if (CNT_W < 1) begin : g_cntWCheck
        $error("CNT_W must be at least 1");
    end

    // Arbitration and next-state logic. The register can take a word when it
    // is empty or being drained this cycle. On a tie the input that did not
    // win last is favoured; last_grant only moves on an actual transfer, so
    // idle cycles leave the priority where it was. Readies are held low while
    // reset is asserted so no word is consumed during reset.
    always_comb begin
        w_load      = 1'b0;
        w_grant     = 1'b0;
        w_xfer0     = 1'b0;
        w_xfer1     = 1'b0;
        w_stateNext = r_state;

        w_load = ~reset & ((r_state == EMPTY) | bus.out_ready);

        if (bus.in0_valid && bus.in1_valid) begin
            w_grant = ~r_lastGrant;
        end else begin
            w_grant = bus.in1_valid;
        end

        w_xfer0 = w_load & ~w_grant & bus.in0_valid;
        w_xfer1 = w_load &  w_grant & bus.in1_valid;

        case (r_state)
            EMPTY: begin
                if (w_xfer0 || w_xfer1) begin
                    w_stateNext = FULL;
                end
            end
            FULL: begin
                if (!(w_xfer0 || w_xfer1) && bus.out_ready) begin
                    w_stateNext = EMPTY;
                end
            end
            default: begin
                w_stateNext = EMPTY;
            end
        endcase
    end

    // Output register, select and round-robin pointer. Data and select only
    // change on a transfer, so they are stable across stalls and keep their
    // last value after a drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_outData   <= '0;
            r_select    <= 1'b0;
            r_lastGrant <= 1'b1;
        end else begin
            r_state <= w_stateNext;
            if (w_xfer0) begin
                r_outData   <= bus.in0_data;
                r_select    <= 1'b0;
                r_lastGrant <= 1'b0;
            end else if (w_xfer1) begin
                r_outData   <= bus.in1_data;
                r_select    <= 1'b1;
                r_lastGrant <= 1'b1;
            end
        end
    end

    assign bus.in0_ready = w_xfer0;
    assign bus.in1_ready = w_xfer1;
    assign bus.out_valid = (r_state == FULL);
    assign bus.out_data  = r_outData;
    assign bus.select    = r_select;

`ifdef GRANT_CNT_EN
    logic [CNT_W-1:0] r_grantCnt0;
    logic [CNT_W-1:0] r_grantCnt1;

    // Per-input accepted-word counters; they stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grantCnt0 <= '0;
            r_grantCnt1 <= '0;
        end else begin
            if (w_xfer0 && (r_grantCnt0 != '1)) begin
                r_grantCnt0 <= r_grantCnt0 + CNT_W'(1);
            end
            if (w_xfer1 && (r_grantCnt1 != '1)) begin
                r_grantCnt1 <= r_grantCnt1 + CNT_W'(1);
            end
        end
    end

    assign grant_cnt0 = r_grantCnt0;
    assign grant_cnt1 = r_grantCnt1;
`endif

endmodule

// File: tb/tb_mux_2to1_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux_2to1_rr_arbiter
//   Self-checking bench for mux_2to1_rr_arbiter. A table of per-cycle vectors
//   gives the inputs, the expected readies and the expected out_valid; words
//   accepted are pushed onto a scoreboard and popped when they should appear
//   on out_data/select one cycle later. Reset sequences are hand-written.
//   Define GRANT_CNT_EN to also exercise the saturating grant counters.
// ----------------------------------------------------------------------------
module tb_mux_2to1_rr_arbiter;

    localparam int WIDTH = 1;
    localparam int CNT_W = 2;

    typedef struct {
        logic             in0v;
        logic [WIDTH-1:0] in0d;
        logic             in1v;
        logic [WIDTH-1:0] in1d;
        logic             outRdy;
        logic             expR0;
        logic             expR1;
        logic             expOV;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             sel;
    } sb_t;

    logic clk;
    logic reset;

    mux_2to1_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

`ifdef GRANT_CNT_EN
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;
`endif

    mux_2to1_rr_arbiter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef GRANT_CNT_EN
        ,
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1)
`endif
    );

    int               checks;
    int               failures;
    sb_t              sbQ[$];
    logic [WIDTH-1:0] heldData;
    logic             heldSel;
    int               expCnt0;
    int               expCnt1;
    vec_t             vecs[16];

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Compare registered outputs against the scoreboard / held values.
    task automatic checkOutput(input logic expOV, input bit pending, input string tag);
        sb_t item;
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(expOV));
        if (pending) begin
            if (sbQ.size() == 0) begin
                check({tag, ".scoreboard_nonempty"}, 32'(0), 32'(1));
            end else begin
                item     = sbQ.pop_front();
                heldData = item.data;
                heldSel  = item.sel;
            end
        end
        check({tag, ".out_data"}, 32'(bus.out_data), 32'(heldData));
        check({tag, ".select"}, 32'(bus.select), 32'(heldSel));
`ifdef GRANT_CNT_EN
        check({tag, ".grant_cnt0"}, 32'(grant_cnt0), 32'(expCnt0));
        check({tag, ".grant_cnt1"}, 32'(grant_cnt1), 32'(expCnt1));
`endif
    endtask

    // One cycle of stimulus: drive at negedge, check readies, push the
    // accepted word, then check outputs just after the posedge.
    task automatic applyStimulus(input vec_t v, input string tag);
        bit pending;
        @(negedge clk);
        reset         = 1'b0;
        bus.in0_valid = v.in0v;
        bus.in0_data  = v.in0d;
        bus.in1_valid = v.in1v;
        bus.in1_data  = v.in1d;
        bus.out_ready = v.outRdy;
        #1;
        check({tag, ".in0_ready"}, 32'(bus.in0_ready), 32'(v.expR0));
        check({tag, ".in1_ready"}, 32'(bus.in1_ready), 32'(v.expR1));
        pending = 1'b0;
        if (v.expR0 && v.in0v) begin
            sbQ.push_back('{data: v.in0d, sel: 1'b0});
            pending = 1'b1;
            if (expCnt0 < (1 << CNT_W) - 1) expCnt0++;
        end else if (v.expR1 && v.in1v) begin
            sbQ.push_back('{data: v.in1d, sel: 1'b1});
            pending = 1'b1;
            if (expCnt1 < (1 << CNT_W) - 1) expCnt1++;
        end
        @(posedge clk);
        #1;
        checkOutput(v.expOV, pending, tag);
    endtask

    // Hold reset with both producers valid; nothing may be accepted and the
    // outputs must show their reset values.
    task automatic doReset(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            reset         = 1'b1;
            bus.in0_valid = 1'b1;
            bus.in0_data  = 1'b1;
            bus.in1_valid = 1'b1;
            bus.in1_data  = 1'b1;
            bus.out_ready = 1'b1;
            #1;
            check($sformatf("%s%0d.in0_ready", tag, c), 32'(bus.in0_ready), 32'(0));
            check($sformatf("%s%0d.in1_ready", tag, c), 32'(bus.in1_ready), 32'(0));
            @(posedge clk);
            #1;
            check($sformatf("%s%0d.out_valid", tag, c), 32'(bus.out_valid), 32'(0));
            check($sformatf("%s%0d.select", tag, c), 32'(bus.select), 32'(0));
            check($sformatf("%s%0d.out_data", tag, c), 32'(bus.out_data), 32'(0));
        end
        sbQ.delete();
        heldData = '0;
        heldSel  = 1'b0;
        expCnt0  = 0;
        expCnt1  = 0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        heldData = '0;
        heldSel  = 1'b0;
        expCnt0  = 0;
        expCnt1  = 0;
        reset    = 1'b1;
        bus.in0_valid = 1'b1;
        bus.in0_data  = 1'b0;
        bus.in1_valid = 1'b1;
        bus.in1_data  = 1'b0;
        bus.out_ready = 1'b0;

        //              in0v  in0d  in1v  in1d  rdy   expR0 expR1 expOV
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}; // only in0
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}; // only in1, drain+load
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // tie -> 0
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}; // tie -> 1
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // tie -> 0
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}; // tie -> 1
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // stall
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // stall
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // stall
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // release -> in0
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // drain only
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // idle
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // tie after idle -> 1
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // stall
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // drain only
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}; // in0, last_grant=0

        doReset(2, "reset");

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while FULL with last_grant=0: word dropped, priority restored.
        doReset(1, "midReset");
        applyStimulus('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}, "postResetTie");

`ifdef GRANT_CNT_EN
        // Counter saturation: five in1 transfers with CNT_W=2.
        doReset(1, "cntReset");
        for (int i = 0; i < 5; i++) begin
            applyStimulus('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
                          $sformatf("cnt%0d", i));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
